counter_checker: RTL and testbench

//  Receive-side monitor for the free-running N-bit up-counter output bus: consumes the counter's out[] each

---
 rtl/counter_checker.sv | 108 ++++++++++
 tb/tb_counter_checker.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/counter_checker.sv
// Receive-side monitor for a free-running WIDTH-bit up-counter: tracks the expected
// next value, flags discontinuities, and counts verified wraps and errors (saturating).
module counter_checker #(
  parameter int WIDTH  = 4,
  parameter int ERR_W  = 8,
  parameter int WRAP_W = 8
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              chk_en,
  input  logic              clr,
  input  logic              dut_rstn,
  input  logic [WIDTH-1:0]  cnt_in,
  output logic              locked,
  output logic              err_pulse,
  output logic [ERR_W-1:0]  err_cnt,
  output logic [WRAP_W-1:0] wrap_cnt,
  output logic [WIDTH-1:0]  exp_val
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SYNC  = 2'd1;
  localparam logic [1:0] TRACK = 2'd2;

  localparam logic [WIDTH-1:0] ALL_ONES = '1;

  logic [1:0]       state, state_nxt;
  logic [WIDTH-1:0] exp_nxt;
  logic             prev_max, prev_max_nxt;
  logic             err_p0, wrap_p0;

  function automatic logic [ERR_W-1:0] sat_inc_err(input logic [ERR_W-1:0] v);
    return (&v) ? v : v + ERR_W'(1);
  endfunction

  function automatic logic [WRAP_W-1:0] sat_inc_wrap(input logic [WRAP_W-1:0] v);
    return (&v) ? v : v + WRAP_W'(1);
  endfunction

  // Stage p0: decide on the sampled cnt_in/dut_rstn
  always_comb begin
    state_nxt    = state;
    exp_nxt      = exp_val;
    prev_max_nxt = prev_max;
    err_p0       = 1'b0;
    wrap_p0      = 1'b0;
    case (state)
      IDLE: begin
        if (chk_en) state_nxt = SYNC;
      end
      SYNC: begin
        if (!chk_en) begin
          state_nxt = IDLE;
        end else begin
          state_nxt    = TRACK;
          exp_nxt      = dut_rstn ? cnt_in + WIDTH'(1) : '0;
          prev_max_nxt = 1'b0;
        end
      end
      TRACK: begin
        if (!chk_en) begin
          state_nxt = IDLE;
        end else if (!dut_rstn) begin
          err_p0       = (cnt_in != '0);
          exp_nxt      = '0;
          prev_max_nxt = 1'b0;
        end else if (cnt_in == exp_val) begin
          // prev_max only set by a matched all-ones sample, so a wrap across reset is not counted
          wrap_p0      = (cnt_in == '0) && prev_max;
          prev_max_nxt = (cnt_in == ALL_ONES);
          exp_nxt      = exp_val + WIDTH'(1);
        end else begin
          err_p0       = 1'b1;
          exp_nxt      = cnt_in + WIDTH'(1);
          prev_max_nxt = 1'b0;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Stage p1: registered outputs
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= IDLE;
      exp_val   <= '0;
      prev_max  <= 1'b0;
      locked    <= 1'b0;
      err_pulse <= 1'b0;
      err_cnt   <= '0;
      wrap_cnt  <= '0;
    end else begin
      state     <= state_nxt;
      exp_val   <= exp_nxt;
      prev_max  <= prev_max_nxt;
      locked    <= (state_nxt == TRACK);
      err_pulse <= err_p0;
      if (clr) begin
        err_cnt  <= '0;
        wrap_cnt <= '0;
      end else begin
        if (err_p0)  err_cnt  <= sat_inc_err(err_cnt);
        if (wrap_p0) wrap_cnt <= sat_inc_wrap(wrap_cnt);
      end
    end
  end

endmodule

// File: tb/tb_counter_checker.sv
// Scoreboard bench for counter_checker: a behavioural model pushes expected outputs
// per driven cycle; they are popped and compared one time unit after the clock edge.
module tb_counter_checker;

  logic       clk;
  logic       rstn;
  logic       chk_en;
  logic       clr;
  logic       dut_rstn;
  logic [3:0] cnt_in;
  logic       locked;
  logic       err_pulse;
  logic [7:0] err_cnt;
  logic [7:0] wrap_cnt;
  logic [3:0] exp_val;

  counter_checker #(.WIDTH(4), .ERR_W(8), .WRAP_W(8)) dut (
    .clk(clk), .rstn(rstn), .chk_en(chk_en), .clr(clr), .dut_rstn(dut_rstn),
    .cnt_in(cnt_in), .locked(locked), .err_pulse(err_pulse), .err_cnt(err_cnt),
    .wrap_cnt(wrap_cnt), .exp_val(exp_val)
  );

  typedef struct {
    logic       locked;
    logic       pulse;
    logic [7:0] err;
    logic [7:0] wrap;
    logic [3:0] expv;
  } exp_t;

  exp_t sb[$];

  int n_cmp = 0;
  int n_err = 0;

  int         m_state;
  logic [3:0] m_exp;
  logic       m_prev;
  logic [7:0] m_err;
  logic [7:0] m_wrap;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    if (obs !== expv) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    m_state = 0;
    m_exp   = 4'd0;
    m_prev  = 1'b0;
    m_err   = 8'd0;
    m_wrap  = 8'd0;
  endtask

  task automatic model(input logic en, input logic cl, input logic dr, input logic [3:0] c);
    logic det;
    logic wr;
    exp_t e;
    det = 1'b0;
    wr  = 1'b0;
    case (m_state)
      0: if (en) m_state = 1;
      1: begin
        if (!en) m_state = 0;
        else begin
          m_exp   = dr ? c + 4'd1 : 4'd0;
          m_prev  = 1'b0;
          m_state = 2;
        end
      end
      default: begin
        if (!en) m_state = 0;
        else if (!dr) begin
          det    = (c != 4'd0);
          m_exp  = 4'd0;
          m_prev = 1'b0;
        end else if (c == m_exp) begin
          wr     = (c == 4'd0) && m_prev;
          m_prev = (c == 4'hF);
          m_exp  = m_exp + 4'd1;
        end else begin
          det    = 1'b1;
          m_exp  = c + 4'd1;
          m_prev = 1'b0;
        end
      end
    endcase
    if (cl) begin
      m_err  = 8'd0;
      m_wrap = 8'd0;
    end else begin
      if (det && m_err != 8'hFF) m_err = m_err + 8'd1;
      if (wr && m_wrap != 8'hFF) m_wrap = m_wrap + 8'd1;
    end
    e.locked = (m_state == 2);
    e.pulse  = det;
    e.err    = m_err;
    e.wrap   = m_wrap;
    e.expv   = m_exp;
    sb.push_back(e);
  endtask

  task automatic step(input logic en, input logic cl, input logic dr, input logic [3:0] c);
    exp_t e;
    chk_en   = en;
    clr      = cl;
    dut_rstn = dr;
    cnt_in   = c;
    model(en, cl, dr, c);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      chk("sb_empty", 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      chk("locked", locked, e.locked);
      chk("err_pulse", err_pulse, e.pulse);
      chk("err_cnt", err_cnt, e.err);
      chk("wrap_cnt", wrap_cnt, e.wrap);
      chk("exp_val", exp_val, e.expv);
    end
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_locked"}, locked, 1'b0);
    chk({tag, "_pulse"}, err_pulse, 1'b0);
    chk({tag, "_err"}, err_cnt, 8'd0);
    chk({tag, "_wrap"}, wrap_cnt, 8'd0);
    chk({tag, "_exp"}, exp_val, 4'd0);
  endtask

  initial begin
    logic [3:0] t2_seq [5];
    logic [3:0] c;
    t2_seq = '{4'd2, 4'd3, 4'd5, 4'd6, 4'd7};
    rstn = 1'b0; chk_en = 1'b0; clr = 1'b0; dut_rstn = 1'b1; cnt_in = 4'd0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_reset_values("rst");
    @(negedge clk);
    rstn = 1'b1;

    // T1: lock and one verified wrap
    for (int i = 0; i < 18; i++) step(1'b1, 1'b0, 1'b1, 4'(i));
    chk("t1_wrap", wrap_cnt, 8'd1);
    chk("t1_err", err_cnt, 8'd0);
    chk("t1_locked", locked, 1'b1);

    // T2: a single skip gives one error
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b1, t2_seq[i]);
    chk("t2_err", err_cnt, 8'd1);

    // T3: counter reset with cnt_in=0 is clean, no wrap counted
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0, 4'd0);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b1, 4'(i));
    chk("t3_err", err_cnt, 8'd1);
    chk("t3_wrap", wrap_cnt, 8'd1);

    // T4: counter in reset but stuck at 3
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0, 4'd3);
    chk("t4_err", err_cnt, 8'd5);
    step(1'b1, 1'b0, 1'b1, 4'd0);
    step(1'b1, 1'b0, 1'b1, 4'd1);

    // chk_en drop: no compare while idle, relock via SYNC
    step(1'b0, 1'b0, 1'b1, 4'd2);
    chk("en_unlock", locked, 1'b0);
    step(1'b0, 1'b0, 1'b1, 4'd9);
    step(1'b1, 1'b0, 1'b1, 4'd9);
    step(1'b1, 1'b0, 1'b1, 4'd4);
    step(1'b1, 1'b0, 1'b1, 4'd5);
    chk("en_err", err_cnt, 8'd5);

    // T5: saturation, then clr with a same-edge error
    for (int i = 0; i < 300; i++) step(1'b1, 1'b0, 1'b1, (i % 2 == 1) ? 4'd8 : 4'd0);
    chk("t5_sat", err_cnt, 8'hFF);
    step(1'b1, 1'b1, 1'b1, 4'd0);
    chk("t5_clr_err", err_cnt, 8'd0);
    chk("t5_clr_pulse", err_pulse, 1'b1);

    // T6: async reset mid-TRACK
    step(1'b1, 1'b0, 1'b1, 4'd1);
    step(1'b1, 1'b0, 1'b1, 4'd7);
    step(1'b1, 1'b0, 1'b1, 4'd8);
    rstn = 1'b0;
    model_reset();
    #1;
    check_reset_values("t6");
    @(negedge clk);
    rstn = 1'b1;
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b1, 4'(i + 10));
    chk("t6_relock", locked, 1'b1);

    // mixed traffic: mostly counting with occasional jumps and counter resets
    c = 4'd15;
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 9) == 0) c = 4'($urandom_range(0, 15));
      else c = c + 4'd1;
      if ($urandom_range(0, 14) == 0) begin
        step(1'b1, 1'b0, 1'b0, 4'd0);
        c = 4'd15;
      end else begin
        step(1'b1, ($urandom_range(0, 19) == 0), 1'b1, c);
      end
    end

    chk("sb_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
